// File: rtl/fifo_write.sv
// -----------------------------------------------------------------------------
// fifo_write
// Write-side control for the asynchronous FIFO. Owns the binary write pointer,
// brings the read pointer into the write clock domain through a two-flop
// synchronizer, and produces full / almost-full / occupancy status. The memory
// write strobe is gated so the storage array is never written past capacity.
//
// Optional feature macro: FIFO_WR_OVF_EN
//   When defined, adds a sticky overflow flag and a saturating 8-bit drop
//   counter. When undefined, those ports and their logic are absent and
//   dropped writes are silent.
//
// Ports:
//   w_clk          in   write clock
//   wresetn        in   asynchronous active-low reset
//   flush          in   synchronous clear of the write side
//   wr_enable      in   write request from the producer
//   read_ptr       in   binary read pointer from fifo_read (PTR_WIDTH+1 bits)
//   fifo_wr_enable out  memory write strobe (combinational)
//   full           out  FIFO full
//   almost_full    out  free slots <= AF_MARGIN
//   write_ptr      out  binary write pointer; address is write_ptr[PTR_WIDTH-1:0]
//   wr_count       out  occupancy as seen from the write domain
//   overflow       out  sticky drop flag      (FIFO_WR_OVF_EN only)
//   ovf_count      out  saturating drop count (FIFO_WR_OVF_EN only)
// -----------------------------------------------------------------------------
module fifo_write #(
    parameter int DATA_WIDTH  = 8,
    parameter int PTR_WIDTH   = 4,
    parameter int DEPTH_WIDTH = 16,
    parameter int AF_MARGIN   = 2
) (
    input  logic                 w_clk,
    input  logic                 wresetn,
    input  logic                 flush,
    input  logic                 wr_enable,
    input  logic [PTR_WIDTH:0]   read_ptr,
    output logic                 fifo_wr_enable,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   write_ptr,
    output logic [PTR_WIDTH:0]   wr_count
`ifdef FIFO_WR_OVF_EN
    ,
    output logic                 overflow,
    output logic [7:0]           ovf_count
`endif
);

    localparam int               AF_THRESH_I = DEPTH_WIDTH - AF_MARGIN;
    localparam logic [PTR_WIDTH:0] AF_THRESH = AF_THRESH_I[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] PTR_ONE   = {{PTR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH:0] PTR_ZERO  = {(PTR_WIDTH+1){1'b0}};

    logic [PTR_WIDTH:0] rptr_s1;
    logic [PTR_WIDTH:0] rptr_s2;
    logic [PTR_WIDTH:0] write_ptr_r;
    logic [PTR_WIDTH:0] wr_count_s;
    logic               full_s;
    logic               almost_full_s;
    logic               fifo_wr_enable_s;

    // Two-flop synchronizer carrying the read pointer into the write domain.
    always_ff @(posedge w_clk or negedge wresetn) begin
        if (!wresetn) begin
            rptr_s1 <= PTR_ZERO;
            rptr_s2 <= PTR_ZERO;
        end else begin
            rptr_s1 <= read_ptr;
            rptr_s2 <= rptr_s1;
        end
    end

    // Status decode and write strobe; all status uses the synchronized pointer.
    always_comb begin
        full_s           = 1'b0;
        almost_full_s    = 1'b0;
        fifo_wr_enable_s = 1'b0;
        wr_count_s       = write_ptr_r - rptr_s2;

        // Full: same slot index, opposite lap.
        if ((write_ptr_r[PTR_WIDTH] != rptr_s2[PTR_WIDTH]) &&
            (write_ptr_r[PTR_WIDTH-1:0] == rptr_s2[PTR_WIDTH-1:0])) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end

        if (full_s || (wr_count_s >= AF_THRESH)) begin
            almost_full_s = 1'b1;
        end else begin
            almost_full_s = 1'b0;
        end

        fifo_wr_enable_s = wr_enable && !full_s && !flush;
    end

    // Write pointer: flush wins, otherwise advance on an accepted write.
    always_ff @(posedge w_clk or negedge wresetn) begin
        if (!wresetn) begin
            write_ptr_r <= PTR_ZERO;
        end else if (flush) begin
            write_ptr_r <= PTR_ZERO;
        end else if (fifo_wr_enable_s) begin
            write_ptr_r <= write_ptr_r + PTR_ONE;
        end else begin
            write_ptr_r <= write_ptr_r;
        end
    end

`ifdef FIFO_WR_OVF_EN
    logic       overflow_r;
    logic [7:0] ovf_count_r;
    logic       drop_s;

    assign drop_s = wr_enable && full_s && !flush;

    // Sticky drop flag and saturating drop counter.
    always_ff @(posedge w_clk or negedge wresetn) begin
        if (!wresetn) begin
            overflow_r  <= 1'b0;
            ovf_count_r <= 8'd0;
        end else if (flush) begin
            overflow_r  <= 1'b0;
            ovf_count_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r  <= 1'b1;
            ovf_count_r <= (ovf_count_r == 8'hFF) ? 8'hFF : (ovf_count_r + 8'd1);
        end else begin
            overflow_r  <= overflow_r;
            ovf_count_r <= ovf_count_r;
        end
    end

    assign overflow  = overflow_r;
    assign ovf_count = ovf_count_r;
`endif

    assign fifo_wr_enable = fifo_wr_enable_s;
    assign full           = full_s;
    assign almost_full    = almost_full_s;
    assign write_ptr      = write_ptr_r;
    assign wr_count       = wr_count_s;

endmodule

// File: tb/tb_fifo_write.sv
// -----------------------------------------------------------------------------
// tb_fifo_write
// Directed self-checking bench for fifo_write with default parameters.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fifo_write;

    logic       w_clk;
    logic       wresetn;
    logic       flush;
    logic       wr_enable;
    logic [4:0] read_ptr;
    logic       fifo_wr_enable;
    logic       full;
    logic       almost_full;
    logic [4:0] write_ptr;
    logic [4:0] wr_count;
`ifdef FIFO_WR_OVF_EN
    logic       overflow;
    logic [7:0] ovf_count;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_write #(
        .DATA_WIDTH (8),
        .PTR_WIDTH  (4),
        .DEPTH_WIDTH(16),
        .AF_MARGIN  (2)
    ) dut (
        .w_clk         (w_clk),
        .wresetn       (wresetn),
        .flush         (flush),
        .wr_enable     (wr_enable),
        .read_ptr      (read_ptr),
        .fifo_wr_enable(fifo_wr_enable),
        .full          (full),
        .almost_full   (almost_full),
        .write_ptr     (write_ptr),
        .wr_count      (wr_count)
`ifdef FIFO_WR_OVF_EN
        ,
        .overflow      (overflow),
        .ovf_count     (ovf_count)
`endif
    );

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    initial begin
        wresetn   = 1'b0;
        flush     = 1'b0;
        wr_enable = 1'b0;
        read_ptr  = 5'd0;
        tick();
        tick();

        // Reset state
        check("rst_write_ptr", 32'(write_ptr), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        wr_enable = 1'b1;
        #1;
        check("rst_strobe_follows", 32'(fifo_wr_enable), 32'd1);
        wr_enable = 1'b0;
        tick();
        check("rst_hold_ptr", 32'(write_ptr), 32'd0);
        wresetn = 1'b1;

        // Fill: 16 writes with read_ptr held at 0
        wr_enable = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            check("fill_strobe", 32'(fifo_wr_enable), 32'd1);
            tick();
            check("fill_ptr", 32'(write_ptr), 32'(i));
            check("fill_count", 32'(wr_count), 32'(i));
            check("fill_af", 32'(almost_full), (i >= 14) ? 32'd1 : 32'd0);
            check("fill_full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
        end
        #1;
        check("write17_strobe", 32'(fifo_wr_enable), 32'd0);

        // Three writes while full are dropped
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("drop_ptr_hold", 32'(write_ptr), 32'h10);
        end
`ifdef FIFO_WR_OVF_EN
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count3", 32'(ovf_count), 32'd3);
`endif
        wr_enable = 1'b0;

        // Drain visibility: read_ptr -> 4, full falls two edges later
        read_ptr = 5'd4;
        tick();
        check("drain_full_d1", 32'(full), 32'd1);
        check("drain_count_d1", 32'(wr_count), 32'd16);
        tick();
        check("drain_full_d2", 32'(full), 32'd0);
        check("drain_count_d2", 32'(wr_count), 32'd12);
        check("drain_af_d2", 32'(almost_full), 32'd0);

        // Flush clears pointer (and drop status)
        flush     = 1'b1;
        wr_enable = 1'b1;
        #1;
        check("flush1_strobe", 32'(fifo_wr_enable), 32'd0);
        tick();
        check("flush1_ptr", 32'(write_ptr), 32'd0);
`ifdef FIFO_WR_OVF_EN
        check("flush_ovf_clr", 32'(overflow), 32'd0);
        check("flush_ovfcnt_clr", 32'(ovf_count), 32'd0);
`endif

        // Build write_ptr = 7, then flush and write together
        flush    = 1'b0;
        read_ptr = 5'd0;
        for (int i = 0; i < 7; i++) tick();
        check("pre_flush_ptr7", 32'(write_ptr), 32'd7);
        check("pre_flush_count7", 32'(wr_count), 32'd7);
        flush = 1'b1;
        #1;
        check("flush_wr_strobe", 32'(fifo_wr_enable), 32'd0);
        tick();
        check("flush_wr_ptr", 32'(write_ptr), 32'd0);
        check("flush_wr_count", 32'(wr_count), 32'd0);
        flush = 1'b0;

        // Wrap: reach write_ptr=31 with read_ptr=16, then one write
        for (int i = 0; i < 15; i++) tick();
        check("wrap_ptr15", 32'(write_ptr), 32'd15);
        wr_enable = 1'b0;
        read_ptr  = 5'd15;
        tick();
        tick();
        check("wrap_count0", 32'(wr_count), 32'd0);
        wr_enable = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        check("wrap_ptr31", 32'(write_ptr), 32'h1F);
        check("wrap_full31", 32'(full), 32'd1);
        wr_enable = 1'b0;
        read_ptr  = 5'h10;
        tick();
        tick();
        check("wrap_pre_full", 32'(full), 32'd0);
        check("wrap_pre_count", 32'(wr_count), 32'd15);
        check("wrap_pre_af", 32'(almost_full), 32'd1);
        wr_enable = 1'b1;
        #1;
        check("wrap_strobe", 32'(fifo_wr_enable), 32'd1);
        tick();
        wr_enable = 1'b0;
        check("wrap_ptr0", 32'(write_ptr), 32'd0);
        check("wrap_full", 32'(full), 32'd1);
        check("wrap_count16", 32'(wr_count), 32'd16);

        // Async reset mid-burst
        read_ptr = 5'd0;
        tick();
        tick();
        check("burst_start_count", 32'(wr_count), 32'd0);
        wr_enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        read_ptr = 5'd2;
        tick();
        tick();
        check("burst_ptr7", 32'(write_ptr), 32'd7);
        check("burst_count5", 32'(wr_count), 32'd5);
        #3;
        wresetn = 1'b0;
        #1;
        check("arst_ptr", 32'(write_ptr), 32'd0);
        check("arst_count", 32'(wr_count), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        check("arst_af", 32'(almost_full), 32'd0);
        check("arst_strobe", 32'(fifo_wr_enable), 32'd1);
        read_ptr = 5'd0;
        tick();
        wresetn = 1'b1;
        tick();
        check("post_rst_ptr1", 32'(write_ptr), 32'd1);
        check("post_rst_count1", 32'(wr_count), 32'd1);
        wr_enable = 1'b0;
        tick();
        check("post_rst_hold", 32'(write_ptr), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_write.md
# fifo_write

Write-side control for the asynchronous FIFO: owns the binary write pointer, brings the read pointer into the write clock domain, and generates full, almost-full and occupancy status. It gates the memory write strobe so the storage array is never written past capacity. It pairs with `fifo_read` on the opposite clock domain, exchanging `write_ptr` and `read_ptr`.

## Interface
- `DATA_WIDTH`, 8, data width; carried for integration consistency, not used internally.
- `PTR_WIDTH`, 4, address bits; pointers are `PTR_WIDTH+1` bits wide, with the MSB as the wrap bit.
- `DEPTH_WIDTH`, 16, FIFO depth; must equal 2^`PTR_WIDTH`.
- `AF_MARGIN`, 2, `almost_full` asserts when free slots ≤ `AF_MARGIN`.

Ports:
- `w_clk`  in  1  write clock; one clock only.
- `wresetn`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of the write side.
- `wr_enable`  in  1  write request from the producer.
- `read_ptr`  in  `PTR_WIDTH+1`  binary read pointer from `fifo_read`.
- `fifo_wr_enable`  out  1  memory write strobe.
- `full`  out  1  FIFO full.
- `almost_full`  out  1  free slots ≤ `AF_MARGIN`.
- `write_ptr`  out  `PTR_WIDTH+1`  binary write pointer; the memory address is `write_ptr[PTR_WIDTH-1:0]`.
- `wr_count`  out  `PTR_WIDTH+1`  occupancy as seen from the write domain.
- `overflow`  out  1  sticky drop flag; present only with `FIFO_WR_OVF_EN`.
- `ovf_count`  out  8  saturating drop counter; present only with `FIFO_WR_OVF_EN`.

## Operation
- **Synchronizer**
  - `read_ptr` passes through two flops, `rptr_s1` then `rptr_s2`.
  - Both flops reset to 0.
  - All status is computed from `rptr_s2` only.
- **Strobe:** `fifo_wr_enable = wr_enable && !full && !flush`.
- **Pointer update**
  - `flush` = 1: `write_ptr` ← 0, independent of `wr_enable`.
  - Otherwise, when `fifo_wr_enable` = 1: `write_ptr` ← `write_ptr + 1`, modulo 2^(`PTR_WIDTH+1`).
  - Otherwise `write_ptr` holds.
- **Full:** `full` = 1 when `write_ptr[PTR_WIDTH] != rptr_s2[PTR_WIDTH]` and the lower `PTR_WIDTH` bits are equal. It is a combinational decode of registers.
- **Occupancy:** `wr_count = write_ptr - rptr_s2`, computed in `PTR_WIDTH+1` bits with wrap. The range is 0..`DEPTH_WIDTH`.
- **Almost full:** `almost_full = (wr_count >= DEPTH_WIDTH - AF_MARGIN)`. It is also 1 whenever `full` = 1.
- **Boundary behaviour**
  - Write while full: dropped, with no pointer change.
  - Pointer wrap from all-ones to 0 toggles the wrap bit; no special case is needed.
  - Read-side pointer advance is seen 2 `w_clk` cycles late, so `full` deasserts late. This is conservative and never loses data.
- **Reset values**
  - Mid-operation `wresetn` low forces outputs immediately: `write_ptr`=0, `rptr_s1`/`rptr_s2`=0, `full`=0, `almost_full`=0 (for `AF_MARGIN` < `DEPTH_WIDTH`), `wr_count`=0, `fifo_wr_enable`=`wr_enable`.
  - Pending writes are lost.

## Timing
- `fifo_wr_enable` is combinational in the same cycle as `wr_enable`; the memory captures data on that `w_clk` edge.
- `write_ptr`, `wr_count` and `full` update 1 cycle after an accepted write.
- A `read_ptr` change reaches `full`/`wr_count` 2 cycles after it is stable at the input.
- `flush` takes effect on the next edge. In the flush cycle `fifo_wr_enable` = 0.

## Configuration
- **`FIFO_WR_OVF_EN` defined**
  - `overflow` sets on any cycle with `wr_enable && full && !flush`.
  - `ovf_count` increments on the same condition and saturates at 255.
  - Both are cleared by `flush` or reset; reset value 0.
- **Not defined:** `overflow` and `ovf_count` ports and their logic are absent. Dropped writes are silent.

## Test plan
All scenarios use default parameters.
- **Fill:** hold `read_ptr`=0 and issue 16 consecutive writes.
  - `write_ptr` = 5'b10000 and `full`=1 after the 16th.
  - `almost_full`=1 once `wr_count`=14.
  - A 17th write gives `fifo_wr_enable`=0.
- **Overflow** (`FIFO_WR_OVF_EN`): 3 writes while full.
  - `write_ptr` holds at 5'b10000.
  - `overflow`=1, `ovf_count`=3.
  - A following `flush` clears both and sets `write_ptr`=0.
- **Drain visibility:** when full, step `read_ptr` to 5'd4.
  - `full` falls exactly 2 cycles later, with `wr_count`=12 and `almost_full`=0.
- **Wrap:** with `write_ptr`=5'b11111 and `read_ptr`=5'b10000, one write.
  - `write_ptr` becomes 5'b00000 and `full`=1.
- **Flush and write together:** `flush` and `wr_enable` both 1 with `write_ptr`=7.
  - `fifo_wr_enable`=0 and `write_ptr`=0 next cycle.
- **Async reset:** drop `wresetn` mid-burst, between clock edges.
  - All registered outputs read 0 immediately.
  - After release, the first write gives `write_ptr`=1.
